// File: rtl/taxi_rgmii_idelay_cal.sv
// RGMII RX IDELAYE3 eye-finding sequencer: sweeps a shared VAR_LOAD tap, scores
// each scan point from MAC frame status, then parks the delay at the widest eye centre.
module taxi_rgmii_idelay_cal #(
  parameter int TAP_W         = 9,
  parameter int TAP_MAX       = 511,
  parameter int TAP_STEP      = 8,
  parameter int VTC_WAIT      = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int DWELL_CYCLES  = 4096,
  parameter int MIN_GOOD      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rx_good,
  input  logic             rx_bad,
  output logic             idelay_load,
  output logic [TAP_W-1:0] idelay_cntvalue,
  output logic             idelay_en_vtc,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [TAP_W-1:0] eye_start,
  output logic [TAP_W-1:0] eye_len
);

  localparam int RUN_W = TAP_W + 1;

  localparam logic [31:0]      VTC_LAST    = 32'(VTC_WAIT - 1);
  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      DWELL_LAST  = 32'(DWELL_CYCLES - 1);
  localparam logic [TAP_W:0]   STEP_W      = (TAP_W+1)'(TAP_STEP);
  localparam logic [TAP_W:0]   MAX_W       = (TAP_W+1)'(TAP_MAX);
  localparam logic [15:0]      MIN_GOOD_W  = 16'(MIN_GOOD);
  localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);

  typedef enum logic [3:0] {
    IDLE,
    VTC_OFF,
    LOAD,
    SETTLE,
    DWELL,
    EVAL,
    FIN_VTC,
    FIN_LOAD,
    FIN_SETTLE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] run_start_q, run_start_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [RUN_W-1:0] best_len_q, best_len_d;
  logic [15:0]      good_q, good_d;
  logic [15:0]      bad_q, bad_d;

  logic             load_q, load_d;
  logic [TAP_W-1:0] cntvalue_q, cntvalue_d;
  logic             en_vtc_q, en_vtc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [TAP_W-1:0] eye_start_q, eye_start_d;
  logic [TAP_W-1:0] eye_len_q, eye_len_d;

  logic [TAP_W:0]   tap_next_wide;
  logic             tap_pass;
  logic [RUN_W-1:0] run_len_upd;
  logic [TAP_W-1:0] run_start_upd;
  logic [31:0]      eye_span;
  logic [TAP_W-1:0] final_tap;

  // One extra bit on the tap increment so the end-of-scan test cannot wrap.
  assign tap_next_wide = {1'b0, tap_q} + STEP_W;
  assign tap_pass      = (bad_q == 16'd0) && (good_q >= MIN_GOOD_W);
  assign run_len_upd   = tap_pass ? (run_len_q + RUN_ONE) : '0;
  assign run_start_upd = (tap_pass && (run_len_q == '0)) ? tap_q : run_start_q;

  // Centre of the best window, computed wide and truncated back to tap width.
  assign eye_span  = (32'(best_len_q) - 32'd1) * 32'(TAP_STEP);
  assign final_tap = (best_len_q == '0) ? '0 : TAP_W'(32'(best_start_q) + (eye_span >> 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tap_d        = tap_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    good_d       = good_q;
    bad_d        = bad_q;
    load_d       = 1'b0;
    cntvalue_d   = cntvalue_q;
    en_vtc_d     = en_vtc_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    eye_start_d  = eye_start_q;
    eye_len_d    = eye_len_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = VTC_OFF;
          cnt_d        = '0;
          tap_d        = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          en_vtc_d     = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
        end
      end

      VTC_OFF: begin
        if (cnt_q == VTC_LAST) begin
          state_d    = LOAD;
          load_d     = 1'b1;
          cntvalue_d = tap_q;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      LOAD: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = DWELL;
          cnt_d   = '0;
          good_d  = '0;
          bad_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      DWELL: begin
        if (rx_good && (good_q != 16'hFFFF)) good_d = good_q + 16'd1;
        if (rx_bad && (bad_q != 16'hFFFF)) bad_d = bad_q + 16'd1;
        if (cnt_q == DWELL_LAST) begin
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      EVAL: begin
        run_len_d   = run_len_upd;
        run_start_d = run_start_upd;
        // Strictly greater, so an equal-length later window never displaces an earlier one.
        if (run_len_upd > best_len_q) begin
          best_start_d = run_start_upd;
          best_len_d   = run_len_upd;
        end
        if (tap_next_wide <= MAX_W) begin
          tap_d      = tap_next_wide[TAP_W-1:0];
          state_d    = LOAD;
          load_d     = 1'b1;
          cntvalue_d = tap_next_wide[TAP_W-1:0];
        end else begin
          state_d = FIN_VTC;
          cnt_d   = '0;
        end
      end

      FIN_VTC: begin
        if (best_len_q == '0) fail_d = 1'b1;
        if (cnt_q == VTC_LAST) begin
          state_d    = FIN_LOAD;
          load_d     = 1'b1;
          cntvalue_d = final_tap;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      FIN_LOAD: begin
        state_d = FIN_SETTLE;
        cnt_d   = '0;
      end

      FIN_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d     = DONE;
          en_vtc_d    = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          eye_start_d = best_start_q;
          eye_len_d   = TAP_W'(best_len_q);
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      load_q       <= 1'b0;
      cntvalue_q   <= '0;
      en_vtc_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      eye_start_q  <= '0;
      eye_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      load_q       <= load_d;
      cntvalue_q   <= cntvalue_d;
      en_vtc_q     <= en_vtc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      eye_start_q  <= eye_start_d;
      eye_len_q    <= eye_len_d;
    end
  end

  assign idelay_load     = load_q;
  assign idelay_cntvalue = cntvalue_q;
  assign idelay_en_vtc   = en_vtc_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign eye_start       = eye_start_q;
  assign eye_len         = eye_len_q;

endmodule
